// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and helpers shared by the register file, decode and
// writeback blocks.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   bus_slice()             : extract field p of width w from a packed
//                             multi-port bus (LSB-first port packing)
package regfile_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;

  // Widest packed bus and widest single field the slice helper accepts.
  localparam int MAX_BUS_W   = 2048;
  localparam int MAX_FIELD_W = 64;

  // Field p of width w from a zero-extended packed bus; callers truncate the
  // result back to their own field width.
  function automatic logic [MAX_FIELD_W-1:0] bus_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   p,
    input int                   w
  );
    logic [MAX_BUS_W-1:0]   sh;
    logic [MAX_FIELD_W-1:0] mask;
    sh   = bus >> (p * w);
    mask = (MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1);
    return sh[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of read, write, issue and scoreboard signals of the
// multi-port register file.
//   rd_addr/rd_data/rd_busy : read ports (packed, port p at [p*W +: W])
//   wr_en/wr_addr/wr_data   : write ports from writeback
//   issue_en/issue_addr     : destination marking from issue
//   flush                   : clears the whole scoreboard
//   busy_vec                : full scoreboard, bit i = register i busy
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;
  logic [(2**ADDR_W)-1:0]   busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking pending writebacks.
//   clk, rst     : clock, synchronous active-high reset
//   issue_en_i   : mark issue_addr_i busy
//   issue_addr_i : destination register of the issuing instruction
//   flush_i      : clear all busy bits (wins over issue)
//   clr_vec_i    : registers targeted by an enabled write port this cycle
//   busy_vec_o   : registered busy vector; bit 0 is always 0
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_en_i,
  input  logic [ADDR_W-1:0]      issue_addr_i,
  input  logic                   flush_i,
  input  logic [(2**ADDR_W)-1:0] clr_vec_i,
  output logic [(2**ADDR_W)-1:0] busy_vec_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] set_vec;

  always_comb begin
    set_vec = '0;
    if (issue_en_i) set_vec[issue_addr_i] = 1'b1;
    // Set is applied after clear: a newly issued producer outranks the
    // writeback of the previous one.
    busy_d = (busy_q & ~clr_vec_i) | set_vec;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with hard-wired zero
// register, optional same-cycle write bypass and a busy scoreboard.
//   clk, rst : clock, synchronous active-high reset (clears storage and
//              scoreboard; forces rd_data/rd_busy to 0 while high)
//   bus      : regfile_mp_if slave (read ports, write ports, issue, flush,
//              busy_vec)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] ra    [NUM_RD];
  logic [ADDR_W-1:0] wa    [NUM_WR];
  logic [DATA_W-1:0] wd    [NUM_WR];
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  busy_vec;
  logic [DATA_W-1:0] rdat;

  // Unpack the port buses once so the rest of the logic indexes by port.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++)
      ra[p] = ADDR_W'(bus_slice(MAX_BUS_W'(bus.rd_addr), p, ADDR_W));
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w] = ADDR_W'(bus_slice(MAX_BUS_W'(bus.wr_addr), w, ADDR_W));
      wd[w] = DATA_W'(bus_slice(MAX_BUS_W'(bus.wr_data), w, DATA_W));
    end
  end

  // Ascending port loop: the highest-numbered enabled port lands last.
  always_comb begin
    mem_d   = mem_q;
    clr_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w]) begin
        mem_d[wa[w]]   = wd[w];
        clr_vec[wa[w]] = 1'b1;
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .flush_i      (bus.flush),
    .clr_vec_i    (clr_vec),
    .busy_vec_o   (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  // Read path: storage mux, then bypass compare (same priority as storage),
  // then the reset override. r0 is excluded from bypass so it stays 0.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rdat        = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdat = mem_q[ra[p]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (wa[w] == ra[p]) && (ra[p] != '0)) rdat = wd[w];
        end
      end
      if (rst) rdat = '0;
      bus.rd_data[p*DATA_W +: DATA_W] = rdat;
      bus.rd_busy[p] = rst ? 1'b0 : busy_vec[ra[p]];
    end
  end

endmodule
